// File: rtl/me_frame_scheduler.sv
// Frame scheduler for the motion-estimation datapath: packs serial pixel bytes into SRAM A rows,
// copies the block to SRAM B, then steps the processor through every search position.
module me_frame_scheduler #(
    parameter int unsigned ROWS          = 16,
    parameter int unsigned BYTES_PER_ROW = 256,
    parameter int unsigned NUM_POS       = 9,
    parameter int unsigned ADDR_W        = 12
) (
    input  logic              wb_clk_i,
    input  logic              wb_rst_i,
    input  logic              enable,
    input  logic              abort,
    input  logic              pix_valid,
    input  logic              proc_done,
    output logic              row_wr_en,
    output logic [ADDR_W-1:0] row_wr_addr,
    output logic              xfer_en,
    output logic [ADDR_W-1:0] xfer_addr,
    output logic              cmp_en,
    output logic [3:0]        cmp_pos,
    output logic              frame_done,
    output logic              busy,
    output logic              overrun,
    output logic [2:0]        state
);

    localparam int unsigned BYTE_W = (BYTES_PER_ROW > 1) ? $clog2(BYTES_PER_ROW) : 1;
    localparam logic [BYTE_W-1:0] LAST_BYTE = BYTE_W'(BYTES_PER_ROW - 1);
    localparam logic [ADDR_W-1:0] LAST_ROW  = ADDR_W'(ROWS - 1);
    localparam logic [3:0]        LAST_POS  = 4'(NUM_POS - 1);

    typedef enum logic [2:0] {
        StIdle     = 3'd0,
        StFill     = 3'd1,
        StXfer     = 3'd2,
        StCmpIssue = 3'd3,
        StCmpWait  = 3'd4,
        StDone     = 3'd5
    } state_e;

    state_e              r_state;
    logic [BYTE_W-1:0]   r_byte;
    logic [ADDR_W-1:0]   r_row;
    logic [3:0]          r_pos;
    logic                r_row_wr_en;
    logic [ADDR_W-1:0]   r_row_wr_addr;
    logic                r_xfer_en;
    logic [ADDR_W-1:0]   r_xfer_addr;
    logic                r_cmp_en;
    logic [3:0]          r_cmp_pos;
    logic                r_frame_done;
    logic                r_busy;
    logic                r_overrun;

    always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
        if (!wb_rst_i) begin
            r_state       <= StIdle;
            r_byte        <= '0;
            r_row         <= '0;
            r_pos         <= '0;
            r_row_wr_en   <= 1'b0;
            r_row_wr_addr <= '0;
            r_xfer_en     <= 1'b0;
            r_xfer_addr   <= '0;
            r_cmp_en      <= 1'b0;
            r_cmp_pos     <= '0;
            r_frame_done  <= 1'b0;
            r_busy        <= 1'b0;
            r_overrun     <= 1'b0;
        end else begin
            r_row_wr_en  <= 1'b0;
            r_xfer_en    <= 1'b0;
            r_cmp_en     <= 1'b0;
            r_frame_done <= 1'b0;
            if (abort) begin
                r_state   <= StIdle;
                r_busy    <= 1'b0;
                r_byte    <= '0;
                r_row     <= '0;
                r_pos     <= '0;
                r_cmp_pos <= '0;
            end else begin
                if (pix_valid && r_state != StFill) begin
                    r_overrun <= 1'b1;
                end
                case (r_state)
                    StIdle: begin
                        if (enable) begin
                            r_state <= StFill;
                            r_busy  <= 1'b1;
                            r_byte  <= '0;
                            r_row   <= '0;
                            r_pos   <= '0;
                        end
                    end
                    StFill: begin
                        if (pix_valid) begin
                            if (r_byte == LAST_BYTE) begin
                                r_byte        <= '0;
                                r_row_wr_en   <= 1'b1;
                                r_row_wr_addr <= r_row;
                                // Last row write lands in the same cycle the block moves to XFER.
                                if (r_row == LAST_ROW) begin
                                    r_row   <= '0;
                                    r_state <= StXfer;
                                end else begin
                                    r_row <= r_row + 1'b1;
                                end
                            end else begin
                                r_byte <= r_byte + 1'b1;
                            end
                        end
                    end
                    StXfer: begin
                        if (r_xfer_en && r_xfer_addr == LAST_ROW) begin
                            r_state   <= StCmpIssue;
                            r_cmp_en  <= 1'b1;
                            r_cmp_pos <= r_pos;
                        end else begin
                            r_xfer_en   <= 1'b1;
                            r_xfer_addr <= r_xfer_en ? r_xfer_addr + 1'b1 : '0;
                        end
                    end
                    StCmpIssue: begin
                        r_state <= StCmpWait;
                    end
                    StCmpWait: begin
                        if (proc_done) begin
                            if (r_pos == LAST_POS) begin
                                r_state      <= StDone;
                                r_frame_done <= 1'b1;
                            end else begin
                                r_pos     <= r_pos + 4'd1;
                                r_cmp_pos <= r_pos + 4'd1;
                                r_cmp_en  <= 1'b1;
                                r_state   <= StCmpIssue;
                            end
                        end
                    end
                    StDone: begin
                        if (enable) begin
                            r_state <= StFill;
                            r_byte  <= '0;
                            r_row   <= '0;
                            r_pos   <= '0;
                        end else begin
                            r_state <= StIdle;
                            r_busy  <= 1'b0;
                        end
                    end
                    default: begin
                        r_state <= StIdle;
                        r_busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign row_wr_en   = r_row_wr_en;
    assign row_wr_addr = r_row_wr_addr;
    assign xfer_en     = r_xfer_en;
    assign xfer_addr   = r_xfer_addr;
    assign cmp_en      = r_cmp_en;
    assign cmp_pos     = r_cmp_pos;
    assign frame_done  = r_frame_done;
    assign busy        = r_busy;
    assign overrun     = r_overrun;
    assign state       = r_state;

endmodule

// File: tb/tb_me_frame_scheduler.sv
// Bench for me_frame_scheduler: directed frame then randomized stimulus against a behavioural
// model of the framing rules, with asynchronous reset checked between clock edges.
module tb_me_frame_scheduler;

    localparam int unsigned ROWS    = 2;
    localparam int unsigned BPR     = 4;
    localparam int unsigned NUM_POS = 3;
    localparam int unsigned ADDR_W  = 12;

    localparam int M_IDLE = 0, M_FILL = 1, M_XFER = 2, M_ISSUE = 3, M_WAIT = 4, M_DONE = 5;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              enable = 1'b0;
    logic              abort = 1'b0;
    logic              pix_valid = 1'b0;
    logic              proc_done = 1'b0;
    logic              row_wr_en;
    logic [ADDR_W-1:0] row_wr_addr;
    logic              xfer_en;
    logic [ADDR_W-1:0] xfer_addr;
    logic              cmp_en;
    logic [3:0]        cmp_pos;
    logic              frame_done;
    logic              busy;
    logic              overrun;
    logic [2:0]        state;

    me_frame_scheduler #(
        .ROWS         (ROWS),
        .BYTES_PER_ROW(BPR),
        .NUM_POS      (NUM_POS),
        .ADDR_W       (ADDR_W)
    ) u_dut (
        .wb_clk_i   (clk),
        .wb_rst_i   (rst_n),
        .enable     (enable),
        .abort      (abort),
        .pix_valid  (pix_valid),
        .proc_done  (proc_done),
        .row_wr_en  (row_wr_en),
        .row_wr_addr(row_wr_addr),
        .xfer_en    (xfer_en),
        .xfer_addr  (xfer_addr),
        .cmp_en     (cmp_en),
        .cmp_pos    (cmp_pos),
        .frame_done (frame_done),
        .busy       (busy),
        .overrun    (overrun),
        .state      (state)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    int n_frames = 0;

    // Reference model: phase plus plain counters of bytes, rows, remaining transfers, positions.
    int m_phase, m_bytes, m_rows, m_xfer_left, m_pos;
    int m_row_wr_en, m_row_wr_addr, m_xfer_en, m_xfer_addr, m_cmp_en, m_cmp_pos;
    int m_frame_done, m_busy, m_overrun;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic compare_all();
        check_eq("state", 32'(state), m_phase);
        check_eq("busy", 32'(busy), m_busy);
        check_eq("row_wr_en", 32'(row_wr_en), m_row_wr_en);
        check_eq("row_wr_addr", 32'(row_wr_addr), m_row_wr_addr);
        check_eq("xfer_en", 32'(xfer_en), m_xfer_en);
        check_eq("xfer_addr", 32'(xfer_addr), m_xfer_addr);
        check_eq("cmp_en", 32'(cmp_en), m_cmp_en);
        check_eq("cmp_pos", 32'(cmp_pos), m_cmp_pos);
        check_eq("frame_done", 32'(frame_done), m_frame_done);
        check_eq("overrun", 32'(overrun), m_overrun);
    endtask

    task automatic model_reset();
        m_phase = M_IDLE; m_bytes = 0; m_rows = 0; m_xfer_left = 0; m_pos = 0;
        m_row_wr_en = 0; m_row_wr_addr = 0; m_xfer_en = 0; m_xfer_addr = 0;
        m_cmp_en = 0; m_cmp_pos = 0; m_frame_done = 0; m_busy = 0; m_overrun = 0;
    endtask

    task automatic start_frame();
        m_phase = M_FILL; m_bytes = 0; m_rows = 0; m_pos = 0; m_busy = 1;
    endtask

    task automatic model_step(input bit en, input bit ab, input bit pv, input bit pd);
        m_row_wr_en = 0; m_xfer_en = 0; m_cmp_en = 0; m_frame_done = 0;
        if (ab) begin
            m_phase = M_IDLE; m_busy = 0; m_bytes = 0; m_rows = 0; m_pos = 0; m_cmp_pos = 0;
            return;
        end
        if (pv && m_phase != M_FILL) m_overrun = 1;
        case (m_phase)
            M_IDLE: if (en) start_frame();
            M_FILL: if (pv) begin
                m_bytes++;
                if (m_bytes == BPR) begin
                    m_bytes = 0;
                    m_row_wr_en = 1;
                    m_row_wr_addr = m_rows;
                    m_rows++;
                    if (m_rows == ROWS) begin
                        m_rows = 0;
                        m_phase = M_XFER;
                        m_xfer_left = ROWS;
                    end
                end
            end
            M_XFER: if (m_xfer_left > 0) begin
                m_xfer_en = 1;
                m_xfer_addr = ROWS - m_xfer_left;
                m_xfer_left--;
            end else begin
                m_phase = M_ISSUE; m_cmp_en = 1; m_cmp_pos = m_pos;
            end
            M_ISSUE: m_phase = M_WAIT;
            M_WAIT: if (pd) begin
                m_pos++;
                if (m_pos == NUM_POS) begin
                    m_phase = M_DONE; m_frame_done = 1; n_frames++;
                end else begin
                    m_phase = M_ISSUE; m_cmp_en = 1; m_cmp_pos = m_pos;
                end
            end
            M_DONE: if (en) start_frame();
                    else begin m_phase = M_IDLE; m_busy = 0; end
            default: ;
        endcase
    endtask

    // One clock: check at negedge, optionally assert reset and check it before the next edge.
    task automatic cycle(input bit en, input bit ab, input bit pv, input bit pd, input bit rst);
        @(negedge clk);
        compare_all();
        if (rst) begin
            if (rst_n) begin
                rst_n = 1'b0;
                #1;
                model_reset();
                compare_all();
            end
        end else begin
            rst_n = 1'b1;
        end
        enable = en; abort = ab; pix_valid = pv; proc_done = pd;
        @(posedge clk);
        if (rst_n) model_step(en, ab, pv, pd);
    endtask

    initial begin
        model_reset();
        repeat (2) cycle(0, 0, 0, 0, 1);

        // Directed frame: 8 back-to-back bytes, then three positions with 5-cycle processor latency.
        cycle(1, 0, 0, 0, 0);
        for (int i = 0; i < 8; i++) cycle(1, 0, 1, 0, 0);
        for (int p = 0; p < 3; p++) begin
            repeat (5) cycle(0, 0, 0, 0, 0);
            cycle(0, 0, 0, 1, 0);
        end
        repeat (4) cycle(0, 0, 0, 0, 0);
        check_eq("directed_frames", 32'(n_frames), 32'd1);

        // Second frame with enable held through DONE and a byte dropped during CMP_WAIT.
        cycle(1, 0, 0, 0, 0);
        for (int i = 0; i < 8; i++) cycle(1, 0, 1, 0, 0);
        repeat (4) cycle(1, 0, 0, 0, 0);
        cycle(1, 0, 1, 0, 0);
        for (int p = 0; p < 3; p++) begin
            repeat (3) cycle(1, 0, 0, 0, 0);
            cycle(1, 0, 0, 1, 0);
        end
        repeat (3) cycle(1, 0, 0, 0, 0);

        // Abort coinciding with proc_done, then reset asserted mid-XFER.
        for (int i = 0; i < 8; i++) cycle(1, 0, 1, 0, 0);
        repeat (5) cycle(1, 0, 0, 0, 0);
        cycle(1, 1, 0, 1, 0);
        repeat (2) cycle(0, 0, 0, 0, 0);
        cycle(1, 0, 0, 0, 0);
        for (int i = 0; i < 8; i++) cycle(1, 0, 1, 0, 0);
        cycle(1, 0, 0, 0, 1);
        cycle(0, 0, 0, 0, 1);
        cycle(0, 0, 0, 0, 0);

        for (int c = 0; c < 4000; c++) begin
            cycle($urandom_range(0, 9) != 0, $urandom_range(0, 199) == 0,
                  $urandom_range(0, 2) != 0, $urandom_range(0, 3) == 0,
                  $urandom_range(0, 999) == 0);
        end
        cycle(0, 0, 0, 0, 0);
        check_eq("frames_seen", 32'(n_frames > 20), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
